// File: rtl/pattern_detector.sv
// Detects PATTERN (4 bytes, MSB first) repeated n_detec times back-to-back and raises a sticky flag.
// Flag is registered and visible right after the edge that samples the last byte; no backpressure.
module pattern_detector #(
  parameter logic [31:0] PATTERN = 32'hABCDEF23,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       out_PRBS,
  input  logic [CNT_W-1:0] n_detec,
  output logic             Pattern_Flag
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  localparam logic [7:0] BYTE0 = PATTERN[31:24];
  localparam logic [7:0] BYTE1 = PATTERN[23:16];
  localparam logic [7:0] BYTE2 = PATTERN[15:8];
  localparam logic [7:0] BYTE3 = PATTERN[7:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt, count_inc;
  logic             flag_nxt;
  logic [7:0]       exp_byte;

  always_comb begin
    exp_byte = BYTE0;
    case (state)
      S0: exp_byte = BYTE0;
      S1: exp_byte = BYTE1;
      S2: exp_byte = BYTE2;
      S3: exp_byte = BYTE3;
      default: exp_byte = BYTE0;
    endcase
  end

  // Saturate so a long run never wraps back below n_detec.
  assign count_inc = (&count) ? count : count + CNT_ONE;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_nxt  = Pattern_Flag;
    if (out_PRBS == exp_byte) begin
      case (state)
        S0: state_nxt = S1;
        S1: state_nxt = S2;
        S2: state_nxt = S3;
        S3: begin
          state_nxt = S0;
          count_nxt = count_inc;
          if ((n_detec != '0) && (count_inc >= n_detec)) flag_nxt = 1'b1;
        end
        default: state_nxt = S0;
      endcase
    end else begin
      // Any mismatch (including X) breaks the run; a stray first byte restarts the pattern.
      count_nxt = '0;
      if (out_PRBS == BYTE0) state_nxt = S1;
      else                   state_nxt = S0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S0;
      count        <= '0;
      Pattern_Flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      Pattern_Flag <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench: reference model counts whole pattern copies ending at each byte of the history.
module tb_pattern_detector;

  localparam logic [31:0] PAT = 32'hABCDEF23;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] out_PRBS;
  logic [7:0] n_detec;
  logic       Pattern_Flag;

  int errors = 0;
  int checks = 0;

  bit       exp_q[$];
  bit [7:0] hist[$];
  bit       m_flag;

  pattern_detector #(.PATTERN(PAT), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .out_PRBS     (out_PRBS),
    .n_detec      (n_detec),
    .Pattern_Flag (Pattern_Flag)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] pat_byte(input int i);
    logic [31:0] p;
    p = PAT;
    return p[31-8*i -: 8];
  endfunction

  // Number of complete pattern copies that end exactly at the newest byte, capped at 255.
  function automatic int reps();
    int k = 0;
    int n = hist.size();
    bit ok;
    while (k < 255 && n >= 4*(k+1)) begin
      ok = 1'b1;
      for (int j = 0; j < 4; j++)
        if (hist[n-4*(k+1)+j] != pat_byte(j)) ok = 1'b0;
      if (!ok) break;
      k++;
    end
    return k;
  endfunction

  function automatic void model_step(input bit [7:0] b);
    int k;
    hist.push_back(b);
    if (hist.size() > 1100) void'(hist.pop_front());
    k = reps();
    if (k > 0 && n_detec != 0 && k >= int'(n_detec)) m_flag = 1'b1;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_flag = 1'b0;
  endfunction

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: Pattern_Flag=%0b expected=%0b at t=%0t", name, act, req, $time);
    end
  endtask

  // Called just after a falling edge; leaves time at the next falling edge.
  task automatic drive(input bit [7:0] b);
    out_PRBS = b;
    model_step(b);
    exp_q.push_back(m_flag);
    @(negedge clk);
  endtask

  task automatic drive_pat();
    for (int j = 0; j < 4; j++) drive(pat_byte(j));
  endtask

  task automatic pulse_rst(input string name);
    rst = 1'b1;
    #1;
    check(name, Pattern_Flag, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_list(input bit [7:0] bl[$]);
    foreach (bl[i]) drive(bl[i]);
  endtask

  initial begin : monitor
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", Pattern_Flag, e);
      end
    end
  end

  initial begin : stimulus
    int r;
    rst      = 1'b1;
    n_detec  = 8'd2;
    out_PRBS = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", Pattern_Flag, 1'b0);
    rst = 1'b0;

    // Basic n=2
    drive_list('{8'hAB, 8'hCD, 8'hEF, 8'h23, 8'hAB, 8'hCD, 8'hEF});
    check("basic_7th", Pattern_Flag, 1'b0);
    drive(8'h23);
    check("basic_8th", Pattern_Flag, 1'b1);
    repeat (10) drive(8'($urandom_range(0, 255)));
    check("basic_sticky", Pattern_Flag, 1'b1);

    // Single repetition, then n=3
    pulse_rst("rst_single");
    n_detec = 8'd1;
    drive_list('{8'hAB, 8'hCD, 8'hEF});
    check("single_3rd", Pattern_Flag, 1'b0);
    drive(8'h23);
    check("single_4th", Pattern_Flag, 1'b1);
    pulse_rst("rst_n3");
    n_detec = 8'd3;
    drive_pat(); drive_pat();
    check("n3_two", Pattern_Flag, 1'b0);
    drive_pat();
    check("n3_three", Pattern_Flag, 1'b1);

    // Broken repetition
    pulse_rst("rst_broken");
    n_detec = 8'd2;
    drive_list('{8'hAB, 8'hCD, 8'hEF, 8'h23, 8'hAB, 8'hCD, 8'h00, 8'h23,
                 8'hAB, 8'hCD, 8'hEF, 8'h23});
    check("broken", Pattern_Flag, 1'b0);
    drive_pat();
    check("broken_recover", Pattern_Flag, 1'b1);

    // Resync on repeated first byte
    pulse_rst("rst_resync");
    n_detec = 8'd1;
    drive_list('{8'hAB, 8'hAB, 8'hCD, 8'hEF});
    check("resync_a_pre", Pattern_Flag, 1'b0);
    drive(8'h23);
    check("resync_a", Pattern_Flag, 1'b1);
    pulse_rst("rst_resync_b");
    drive_list('{8'hAB, 8'hCD, 8'hAB, 8'hCD, 8'hEF});
    check("resync_b_pre", Pattern_Flag, 1'b0);
    drive(8'h23);
    check("resync_b", Pattern_Flag, 1'b1);

    // Reset mid-stream
    pulse_rst("rst_mid_pre");
    n_detec = 8'd2;
    drive_pat();
    drive_list('{8'hAB, 8'hCD});
    pulse_rst("rst_mid");
    drive_pat();
    check("mid_after_one", Pattern_Flag, 1'b0);
    drive_pat();
    check("mid_after_two", Pattern_Flag, 1'b1);
    pulse_rst("rst_async_drop");

    // n_detec = 0 never fires
    n_detec = 8'd0;
    repeat (5) drive_pat();
    check("n0", Pattern_Flag, 1'b0);

    // Lowering n_detec between completions does not fire retroactively
    pulse_rst("rst_retro");
    n_detec = 8'd3;
    drive_pat(); drive_pat();
    n_detec = 8'd2;
    drive(8'h00);
    check("no_retro", Pattern_Flag, 1'b0);

    // Count saturates rather than wrapping past 255
    pulse_rst("rst_sat");
    n_detec = 8'd0;
    repeat (260) drive_pat();
    n_detec = 8'd255;
    drive_pat();
    check("saturate", Pattern_Flag, 1'b1);

    // Random mix of whole patterns, partial patterns and noise
    for (int blk = 0; blk < 6; blk++) begin
      pulse_rst("rst_rand");
      n_detec = 8'($urandom_range(0, 4));
      for (int i = 0; i < 300; i++) begin
        r = $urandom_range(0, 99);
        if (r < 3) n_detec = 8'($urandom_range(0, 5));
        if (r < 45) drive_pat();
        else if (r < 70) begin
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) drive(pat_byte(j));
        end else drive(8'($urandom_range(0, 255)));
      end
    end

    drive(8'h00);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
